// File: rtl/time_counter.sv
// BCD mm:ss time base for the stopwatch/timer: one-second prescaler, up/down/increment
// modes, a one-cycle tick after each timed step and a sticky zero-reached flag.
module time_counter #(
   parameter int TICK_DIV = 10_000_000,
   parameter int PW       = 24
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        clear,
   input  logic        enable,
   input  logic        enable_increment,
   input  logic        enable_decrement,
   input  logic        inc_pulse,
   output logic [3:0]  sec_ones,
   output logic [3:0]  sec_tens,
   output logic [3:0]  min_ones,
   output logic [3:0]  min_tens,
   output logic [15:0] count_value,
   output logic        tick,
   output logic        flag
);

   typedef enum logic [2:0] {
      MODE_HOLD,
      MODE_CLEAR,
      MODE_DOWN,
      MODE_UP,
      MODE_INC
   } mode_t;

   logic [15:0]   r_count;
   logic [PW-1:0] r_presc;
   logic          r_tick;
   logic          r_flag;

   mode_t         w_mode;
   logic [15:0]   w_countNext;
   logic [PW-1:0] w_prescNext;
   logic          w_tickNext;
   logic          w_flagNext;
   logic          w_wrap;
   logic          w_atZero;

   // Count is held as {min_tens, min_ones, sec_tens, sec_ones}; 59:59 wraps to 00:00.
   function automatic logic [15:0] bcdUp(input logic [15:0] c);
      logic [3:0] so, st, mo, mt;
      {mt, mo, st, so} = c;
      if (so != 4'd9) begin
         so = so + 4'd1;
      end else begin
         so = 4'd0;
         if (st != 4'd5) begin
            st = st + 4'd1;
         end else begin
            st = 4'd0;
            if (mo != 4'd9) begin
               mo = mo + 4'd1;
            end else begin
               mo = 4'd0;
               if (mt != 4'd5) mt = mt + 4'd1;
               else            mt = 4'd0;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   // Down-counting stops at 00:00, so min_tens is never decremented below zero.
   function automatic logic [15:0] bcdDown(input logic [15:0] c);
      logic [3:0] so, st, mo, mt;
      {mt, mo, st, so} = c;
      if (c != 16'h0000) begin
         if (so != 4'd0) begin
            so = so - 4'd1;
         end else begin
            so = 4'd9;
            if (st != 4'd0) begin
               st = st - 4'd1;
            end else begin
               st = 4'd5;
               if (mo != 4'd0) begin
                  mo = mo - 4'd1;
               end else begin
                  mo = 4'd9;
                  mt = mt - 4'd1;
               end
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   always_comb begin
      w_mode = MODE_HOLD;
      if (clear)                 w_mode = MODE_CLEAR;
      else if (enable_decrement) w_mode = MODE_DOWN;
      else if (enable)           w_mode = MODE_UP;
      else if (enable_increment) w_mode = MODE_INC;
   end

   assign w_wrap   = (r_presc == PW'(TICK_DIV - 1));
   assign w_atZero = (r_count == 16'h0000);

   // The prescaler only runs in up/down modes; every other mode parks it at zero.
   always_comb begin
      w_countNext = r_count;
      w_prescNext = '0;
      w_tickNext  = 1'b0;
      w_flagNext  = r_flag;
      case (w_mode)
         MODE_CLEAR: begin
            w_countNext = 16'h0000;
            w_flagNext  = 1'b0;
         end
         MODE_DOWN: begin
            w_prescNext = w_wrap ? '0 : r_presc + PW'(1);
            if (w_atZero) begin
               w_flagNext = 1'b1;
            end else if (w_wrap) begin
               w_countNext = bcdDown(r_count);
               w_tickNext  = 1'b1;
            end
         end
         MODE_UP: begin
            w_prescNext = w_wrap ? '0 : r_presc + PW'(1);
            if (w_wrap) begin
               w_countNext = bcdUp(r_count);
               w_tickNext  = 1'b1;
            end
         end
         MODE_INC: begin
            if (inc_pulse) w_countNext = bcdUp(r_count);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_count <= 16'h0000;
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_flag  <= 1'b0;
      end else begin
         r_count <= w_countNext;
         r_presc <= w_prescNext;
         r_tick  <= w_tickNext;
         r_flag  <= w_flagNext;
      end
   end

   assign sec_ones    = r_count[3:0];
   assign sec_tens    = r_count[7:4];
   assign min_ones    = r_count[11:8];
   assign min_tens    = r_count[15:12];
   assign count_value = r_count;
   assign tick        = r_tick;
   assign flag        = r_flag;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with a 4-cycle second; every scenario task drives
// its own stimulus and compares outputs against hand-computed values.
module tb_time_counter;

   logic        clk;
   logic        nrst;
   logic        clear;
   logic        enable;
   logic        enable_increment;
   logic        enable_decrement;
   logic        inc_pulse;
   logic [3:0]  sec_ones;
   logic [3:0]  sec_tens;
   logic [3:0]  min_ones;
   logic [3:0]  min_tens;
   logic [15:0] count_value;
   logic        tick;
   logic        flag;

   int checkCount = 0;
   int passCount  = 0;

   time_counter #(
      .TICK_DIV(4),
      .PW(8)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .clear(clear),
      .enable(enable),
      .enable_increment(enable_increment),
      .enable_decrement(enable_decrement),
      .inc_pulse(inc_pulse),
      .sec_ones(sec_ones),
      .sec_tens(sec_tens),
      .min_ones(min_ones),
      .min_tens(min_tens),
      .count_value(count_value),
      .tick(tick),
      .flag(flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge and outputs are read there too.
   task automatic applyStimulus(input logic c, input logic e, input logic ei,
                                input logic ed, input logic p, input int n);
      clear            = c;
      enable           = e;
      enable_increment = ei;
      enable_decrement = ed;
      inc_pulse        = p;
      repeat (n) @(negedge clk);
   endtask

   task automatic loadCount(input int n);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      checkCount++;
      if ({min_tens, min_ones, sec_tens, sec_ones, tick, flag} !== 18'h0)
         $display("[TB] FAIL reset_state: got digits=%h tick=%b flag=%b expected 0000/0/0",
                  {min_tens, min_ones, sec_tens, sec_ones}, tick, flag);
      else passCount++;
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_midcount;
      loadCount(0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 148);
      checkCount++;
      if ({sec_tens, sec_ones} !== 8'h37 || count_value !== 16'h0037)
         $display("[TB] FAIL mid_count_0037: got %h expected 0037", count_value);
      else passCount++;
      checkCount++;
      if (tick !== 1'b1 || flag !== 1'b1)
         $display("[TB] FAIL mid_tick_flag: got tick=%b flag=%b expected 1/1", tick, flag);
      else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
      #2 nrst = 1'b0;
      #1;
      checkCount++;
      if (count_value !== 16'h0000 || {min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000
          || tick !== 1'b0 || flag !== 1'b0)
         $display("[TB] FAIL async_reset: got count=%h tick=%b flag=%b expected 0000/0/0",
                  count_value, tick, flag);
      else passCount++;
      @(negedge clk);
      nrst = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      checkCount++;
      if (count_value !== 16'h0000)
         $display("[TB] FAIL presc_reset_early: got %h expected 0000", count_value);
      else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkCount++;
      if (count_value !== 16'h0001)
         $display("[TB] FAIL presc_reset_step: got %h expected 0001", count_value);
      else passCount++;
   endtask

   task automatic test_count_up;
      int ticks;
      ticks = 0;
      loadCount(0);
      enable = 1'b1;
      for (int i = 0; i < 240; i++) begin
         @(negedge clk);
         if (tick === 1'b1) ticks++;
      end
      checkCount++;
      if (count_value !== 16'h0100)
         $display("[TB] FAIL up_240: got %h expected 0100", count_value);
      else passCount++;
      checkCount++;
      if (ticks !== 60)
         $display("[TB] FAIL up_tick_count: got %0d expected 60", ticks);
      else passCount++;
      loadCount(3599);
      checkCount++;
      if (count_value !== 16'h5959 || min_tens !== 4'd5)
         $display("[TB] FAIL preload_5959: got %h expected 5959", count_value);
      else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      checkCount++;
      if (count_value !== 16'h5959 || tick !== 1'b0)
         $display("[TB] FAIL wrap_early: got %h tick=%b expected 5959/0", count_value, tick);
      else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkCount++;
      if (count_value !== 16'h0000 || tick !== 1'b1)
         $display("[TB] FAIL wrap_5959: got %h tick=%b expected 0000/1", count_value, tick);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      checkCount++;
      if (tick !== 1'b0 || flag !== 1'b0)
         $display("[TB] FAIL tick_width: got tick=%b flag=%b expected 0/0", tick, flag);
      else passCount++;
   endtask

   task automatic test_carry;
      int          loads [3] = '{9, 59, 599};
      logic [15:0] exps  [3] = '{16'h0010, 16'h0100, 16'h1000};
      for (int k = 0; k < 3; k++) begin
         loadCount(loads[k]);
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
         checkCount++;
         if (count_value !== exps[k])
            $display("[TB] FAIL carry_%0d: got %h expected %h", k, count_value, exps[k]);
         else passCount++;
      end
   endtask

   task automatic test_increment;
      loadCount(3);
      checkCount++;
      if (count_value !== 16'h0003 || tick !== 1'b0)
         $display("[TB] FAIL inc_three: got %h tick=%b expected 0003/0", count_value, tick);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      checkCount++;
      if (count_value !== 16'h0003)
         $display("[TB] FAIL inc_disabled: got %h expected 0003", count_value);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
      checkCount++;
      if (count_value !== 16'h0003 || flag !== 1'b0)
         $display("[TB] FAIL inc_overridden: got %h flag=%b expected 0003/0", count_value, flag);
      else passCount++;
   endtask

   task automatic test_count_down;
      loadCount(2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
      checkCount++;
      if (count_value !== 16'h0001 || tick !== 1'b1 || flag !== 1'b0)
         $display("[TB] FAIL down_0001: got %h tick=%b flag=%b expected 0001/1/0",
                  count_value, tick, flag);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
      checkCount++;
      if (count_value !== 16'h0000 || tick !== 1'b1 || flag !== 1'b0)
         $display("[TB] FAIL down_0000: got %h tick=%b flag=%b expected 0000/1/0",
                  count_value, tick, flag);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      checkCount++;
      if (flag !== 1'b1 || count_value !== 16'h0000)
         $display("[TB] FAIL flag_set: got flag=%b count=%h expected 1/0000", flag, count_value);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
      checkCount++;
      if (tick !== 1'b0 || count_value !== 16'h0000)
         $display("[TB] FAIL zero_noop: got tick=%b count=%h expected 0/0000", tick, count_value);
      else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkCount++;
      if (flag !== 1'b1)
         $display("[TB] FAIL flag_sticky: got %b expected 1", flag);
      else passCount++;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      checkCount++;
      if (flag !== 1'b0 || count_value !== 16'h0000)
         $display("[TB] FAIL flag_clear: got flag=%b count=%h expected 0/0000", flag, count_value);
      else passCount++;
   endtask

   task automatic test_borrow;
      int          loads [4] = '{60, 600, 10, 3599};
      logic [15:0] exps  [4] = '{16'h0059, 16'h0959, 16'h0009, 16'h5958};
      for (int k = 0; k < 4; k++) begin
         loadCount(loads[k]);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
         checkCount++;
         if (count_value !== exps[k])
            $display("[TB] FAIL borrow_%0d: got %h expected %h", k, count_value, exps[k]);
         else passCount++;
      end
   endtask

   task automatic test_priority;
      loadCount(5);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkCount++;
      if (count_value !== 16'h0000 || tick !== 1'b0)
         $display("[TB] FAIL clear_wins: got %h tick=%b expected 0000/0", count_value, tick);
      else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      checkCount++;
      if (count_value !== 16'h0000)
         $display("[TB] FAIL clear_presc: got %h expected 0000", count_value);
      else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      checkCount++;
      if (count_value !== 16'h0001)
         $display("[TB] FAIL first_step: got %h expected 0001", count_value);
      else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4);
      checkCount++;
      if (count_value !== 16'h0000 || flag !== 1'b0)
         $display("[TB] FAIL down_wins: got %h flag=%b expected 0000/0", count_value, flag);
      else passCount++;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      checkCount++;
      if (flag !== 1'b0)
         $display("[TB] FAIL clear_over_flag: got %b expected 0", flag);
      else passCount++;
   endtask

   initial begin
      clear            = 1'b0;
      enable           = 1'b0;
      enable_increment = 1'b0;
      enable_decrement = 1'b0;
      inc_pulse        = 1'b0;
      nrst             = 1'b0;
      test_reset();
      test_reset_midcount();
      test_count_up();
      test_carry();
      test_increment();
      test_count_down();
      test_borrow();
      test_priority();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
